// File: rtl/pipeline_data_memory_if.sv
// Data-memory bus between the pipeline MEM stage (master) and the data memory (slave).
interface pipeline_data_memory_if;
    logic [63:0] dm_addr;
    logic [63:0] dm_din;
    logic [2:0]  dm_rd_ctrl;
    logic [1:0]  dm_wr_ctrl;
    logic        dm_we;
    logic [63:0] dm_dout;
    logic        dm_fault;

    modport master (
        output dm_addr, dm_din, dm_rd_ctrl, dm_wr_ctrl, dm_we,
        input  dm_dout, dm_fault
    );

    modport slave (
        input  dm_addr, dm_din, dm_rd_ctrl, dm_wr_ctrl, dm_we,
        output dm_dout, dm_fault
    );
endinterface

// File: rtl/pipeline_data_memory.sv
// Byte-addressed 64-bit data memory with combinational extended loads, lane-masked stores,
// alignment/range fault capture and saturating access counters.
module pipeline_data_memory #(
    parameter int    DEPTH_WORDS = 512,
    parameter string INIT_FILE   = "",
    parameter int    CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    pipeline_data_memory_if.slave    bus,
    output logic                     fault_sticky,
    output logic [63:0]              fault_addr,
    output logic [CNT_W-1:0]         rd_count,
    output logic [CNT_W-1:0]         wr_count
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [63:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] wordIndex;
    logic [2:0]       byteOffset;
    logic             outOfRange;
    logic             loadActive;
    logic [2:0]       loadAlign;
    logic [2:0]       storeAlign;
    logic [7:0]       storeSizeMask;
    logic             loadMisaligned;
    logic             storeMisaligned;
    logic             faultNow;
    logic [63:0]      lane;
    logic [63:0]      loadData;
    logic [7:0]       byteMask;
    logic [63:0]      laneData;

    assign wordIndex  = bus.dm_addr[3+IDX_W-1:3];
    assign byteOffset = bus.dm_addr[2:0];
    assign outOfRange = |bus.dm_addr[63:3+IDX_W];
    assign loadActive = (bus.dm_rd_ctrl != 3'b000);

    // Alignment masks hold the offset bits that must be zero for each access size.
    always_comb begin
        loadAlign = 3'b000;
        unique case (bus.dm_rd_ctrl)
            3'b011, 3'b100: loadAlign = 3'b001;
            3'b101, 3'b110: loadAlign = 3'b011;
            3'b111:         loadAlign = 3'b111;
            default:        loadAlign = 3'b000;
        endcase
    end

    always_comb begin
        storeAlign    = 3'b000;
        storeSizeMask = 8'h01;
        unique case (bus.dm_wr_ctrl)
            2'b00: begin storeAlign = 3'b000; storeSizeMask = 8'h01; end
            2'b01: begin storeAlign = 3'b001; storeSizeMask = 8'h03; end
            2'b10: begin storeAlign = 3'b011; storeSizeMask = 8'h0F; end
            2'b11: begin storeAlign = 3'b111; storeSizeMask = 8'hFF; end
            default: begin storeAlign = 3'b000; storeSizeMask = 8'h01; end
        endcase
    end

    assign loadMisaligned  = |(byteOffset & loadAlign);
    assign storeMisaligned = |(byteOffset & storeAlign);
    assign faultNow = (loadActive  & (loadMisaligned  | outOfRange))
                    | (bus.dm_we   & (storeMisaligned | outOfRange));

    assign lane = mem[wordIndex] >> {byteOffset, 3'b000};

    always_comb begin
        loadData = 64'd0;
        unique case (bus.dm_rd_ctrl)
            3'b001:  loadData = {{56{lane[7]}},  lane[7:0]};
            3'b010:  loadData = {56'd0,          lane[7:0]};
            3'b011:  loadData = {{48{lane[15]}}, lane[15:0]};
            3'b100:  loadData = {48'd0,          lane[15:0]};
            3'b101:  loadData = {{32{lane[31]}}, lane[31:0]};
            3'b110:  loadData = {32'd0,          lane[31:0]};
            3'b111:  loadData = lane;
            default: loadData = 64'd0;
        endcase
    end

    assign bus.dm_dout  = (reset || faultNow) ? 64'd0 : loadData;
    assign bus.dm_fault = faultNow;

    assign byteMask = storeSizeMask << byteOffset;
    assign laneData = bus.dm_din << {byteOffset, 3'b000};

    // The array is deliberately left out of reset so stored data survives a pipeline flush.
    always_ff @(posedge clk) begin
        if (!reset && bus.dm_we && !faultNow) begin
            for (int b = 0; b < 8; b++) begin
                if (byteMask[b]) begin
                    mem[wordIndex][b*8 +: 8] <= laneData[b*8 +: 8];
                end
            end
        end
    end

    logic             faultSticky_q, faultSticky_d;
    logic [63:0]      faultAddr_q,   faultAddr_d;
    logic [CNT_W-1:0] rdCount_q,     rdCount_d;
    logic [CNT_W-1:0] wrCount_q,     wrCount_d;

    always_comb begin
        faultSticky_d = faultSticky_q;
        faultAddr_d   = faultAddr_q;
        rdCount_d     = rdCount_q;
        wrCount_d     = wrCount_q;
        if (faultNow && !faultSticky_q) begin
            faultSticky_d = 1'b1;
            faultAddr_d   = bus.dm_addr;
        end
        if (loadActive && !faultNow && rdCount_q != CNT_MAX) begin
            rdCount_d = rdCount_q + 1'b1;
        end
        if (bus.dm_we && !faultNow && wrCount_q != CNT_MAX) begin
            wrCount_d = wrCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            faultSticky_q <= 1'b0;
            faultAddr_q   <= 64'd0;
            rdCount_q     <= '0;
            wrCount_q     <= '0;
        end else begin
            faultSticky_q <= faultSticky_d;
            faultAddr_q   <= faultAddr_d;
            rdCount_q     <= rdCount_d;
            wrCount_q     <= wrCount_d;
        end
    end

    assign fault_sticky = faultSticky_q;
    assign fault_addr   = faultAddr_q;
    assign rd_count     = rdCount_q;
    assign wr_count     = wrCount_q;
endmodule

// File: tb/tb_pipeline_data_memory.sv
// Scoreboard bench for pipeline_data_memory: a byte-level reference model predicts every
// cycle's outputs, and a negedge monitor pops and compares them.
module tb_pipeline_data_memory;
    localparam int DEPTH = 512;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic reset;
    logic faultSticky;
    logic [63:0] faultAddr;
    logic [CW-1:0] rdCount, wrCount;

    pipeline_data_memory_if dmBus ();

    pipeline_data_memory #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (dmBus.slave),
        .fault_sticky (faultSticky),
        .fault_addr   (faultAddr),
        .rd_count     (rdCount),
        .wr_count     (wrCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dout;
        logic        fault;
        int          rdc;
        int          wrc;
        logic        sticky;
        logic [63:0] faddr;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checkCount = 0;
    int passCount  = 0;

    // Reference model: memory as individual bytes keyed by byte address.
    bit [7:0]    modelMem [longint unsigned];
    int          mRd = 0, mWr = 0;
    logic        mSticky = 1'b0;
    logic [63:0] mFaddr = 64'd0;
    int          cntMax = (1 << CW) - 1;

    function automatic int loadBytes(input logic [2:0] rd);
        case (rd)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5, 3'd6: return 4;
            3'd7:       return 8;
            default:    return 1;
        endcase
    endfunction

    task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] din,
                                 input logic [2:0] rd, input logic [1:0] wr,
                                 input logic we, input logic rst, input string name);
        exp_t e;
        int rsz, wsz;
        bit oor, flt;
        logic [63:0] val;
        @(posedge clk);
        #1;
        reset            = rst;
        dmBus.dm_addr    = addr;
        dmBus.dm_din     = din;
        dmBus.dm_rd_ctrl = rd;
        dmBus.dm_wr_ctrl = wr;
        dmBus.dm_we      = we;
        rsz = loadBytes(rd);
        wsz = 1 << wr;
        oor = (addr >= 64'(DEPTH * 8));
        flt = ((rd != 3'd0) && ((addr % rsz) != 0 || oor)) || (we && ((addr % wsz) != 0 || oor));
        val = 64'd0;
        if (!rst && !flt && rd != 3'd0) begin
            for (int i = 0; i < rsz; i++) val = val | (64'(modelMem[addr + 64'(i)]) << (8 * i));
            if ((rd == 3'd1 || rd == 3'd3 || rd == 3'd5) && val[8*rsz-1])
                val = val | ~((64'd1 << (8 * rsz)) - 64'd1);
        end
        e.dout = val; e.fault = flt; e.rdc = mRd; e.wrc = mWr;
        e.sticky = mSticky; e.faddr = mFaddr; e.name = name;
        sb.push_back(e);
        if (rst) begin
            mRd = 0; mWr = 0; mSticky = 1'b0; mFaddr = 64'd0;
        end else begin
            if (rd != 3'd0 && !flt && mRd < cntMax) mRd++;
            if (we && !flt) begin
                for (int i = 0; i < wsz; i++) modelMem[addr + 64'(i)] = din[8*i +: 8];
                if (mWr < cntMax) mWr++;
            end
            if (flt && !mSticky) begin
                mSticky = 1'b1; mFaddr = addr;
            end
        end
    endtask

    task automatic compareOne(input string name, input string field,
                              input logic [63:0] act, input logic [63:0] req);
        checkCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
    endtask

    task automatic checkOutput(input exp_t e);
        compareOne(e.name, "dout",   dmBus.dm_dout, e.dout);
        compareOne(e.name, "fault",  64'(dmBus.dm_fault), 64'(e.fault));
        compareOne(e.name, "rdCnt",  64'(rdCount), 64'(e.rdc));
        compareOne(e.name, "wrCnt",  64'(wrCount), 64'(e.wrc));
        compareOne(e.name, "sticky", 64'(faultSticky), 64'(e.sticky));
        compareOne(e.name, "fAddr",  faultAddr, e.faddr);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic        we, rst;
        logic [63:0] addr, din;
        int          sz;
        reset = 1'b1;
        dmBus.dm_addr = 64'd0; dmBus.dm_din = 64'd0;
        dmBus.dm_rd_ctrl = 3'd0; dmBus.dm_wr_ctrl = 2'd0; dmBus.dm_we = 1'b0;
        @(posedge clk);
        applyStimulus(64'h0, 64'h0, 3'd0, 2'd0, 1'b0, 1'b1, "reset");
        for (int w = 0; w < 32; w++) applyStimulus(64'(w * 8), 64'h0, 3'd0, 2'd3, 1'b1, 1'b0, "preload");
        applyStimulus(64'h0, 64'h0, 3'd0, 2'd0, 1'b0, 1'b1, "reset2");

        applyStimulus(64'h10, 64'h8877665544332211, 3'd0, 2'd3, 1'b1, 1'b0, "sd10");
        applyStimulus(64'h10, 64'h0, 3'd7, 2'd0, 1'b0, 1'b0, "ld10");
        applyStimulus(64'h13, 64'hF0, 3'd0, 2'd0, 1'b1, 1'b0, "sb13");
        applyStimulus(64'h13, 64'h0, 3'd1, 2'd0, 1'b0, 1'b0, "lb13");
        applyStimulus(64'h13, 64'h0, 3'd2, 2'd0, 1'b0, 1'b0, "lbu13");
        applyStimulus(64'h10, 64'h0, 3'd7, 2'd0, 1'b0, 1'b0, "ld10b");
        applyStimulus(64'h16, 64'h0, 3'd5, 2'd0, 1'b0, 1'b0, "lwMis");
        applyStimulus(64'h10, 64'h0, 3'd7, 2'd0, 1'b0, 1'b0, "afterMis");
        applyStimulus(64'h0, 64'h0, 3'd0, 2'd0, 1'b0, 1'b1, "reset3");
        applyStimulus(64'h21, 64'hABCD, 3'd0, 2'd1, 1'b1, 1'b0, "sh21");
        applyStimulus(64'h40000, 64'hABCD, 3'd0, 2'd1, 1'b1, 1'b0, "shOor");
        applyStimulus(64'h20, 64'h0, 3'd7, 2'd0, 1'b0, 1'b0, "ld20");
        applyStimulus(64'h18, 64'hDEADBEEF, 3'd6, 2'd2, 1'b1, 1'b0, "swLwu18");
        applyStimulus(64'h18, 64'h0, 3'd6, 2'd0, 1'b0, 1'b0, "lwu18");
        applyStimulus(64'h18, 64'h0, 3'd5, 2'd0, 1'b0, 1'b0, "lw18");
        for (int i = 0; i < 20; i++) applyStimulus(64'h10, 64'h0, 3'd7, 2'd0, 1'b0, 1'b0, "ldSat");
        applyStimulus(64'h10, 64'h1122, 3'd0, 2'd3, 1'b1, 1'b1, "sdInReset");
        applyStimulus(64'h10, 64'h0, 3'd7, 2'd0, 1'b0, 1'b0, "ldKept");

        for (int i = 0; i < 400; i++) begin
            rd  = 3'($urandom_range(0, 7));
            wr  = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 39) == 0);
            din = {$urandom, $urandom};
            sz  = we ? (1 << wr) : loadBytes(rd);
            if ($urandom_range(0, 9) == 0)
                addr = 64'h1000 + 64'($urandom_range(0, 4095));
            else if ($urandom_range(0, 3) == 0)
                addr = 64'($urandom_range(0, 255));
            else
                addr = 64'($urandom_range(0, 31) * 8 + $urandom_range(0, 8 / sz - 1) * sz);
            applyStimulus(addr, din, rd, wr, we, rst, "rand");
        end

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
